// File: rtl/flit_stim_gen.sv
// Packet/flit stimulus generator: emits pattern flits split into two operands,
// with idle gaps between packets, valid/ready backpressure and a toggle-activity counter.
module flit_stim_gen #(
  parameter int unsigned N     = 22,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [LEN_W-1:0] payload_len_i,
  input  logic [LEN_W-1:0] gap_len_i,
  input  logic [LEN_W-1:0] num_pkts_i,
  input  logic [31:0]      seed_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [N-1:0]     op_a_o,
  output logic [N-1:0]     op_b_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] toggle_count_o,
  output logic [CNT_W-1:0] flit_count_o
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned TW = $clog2(W + 1);
  localparam logic [31:0] LfsrMask = 32'h8020_0003;

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [LEN_W-1:0] plen_q, gap_q, pkt_q, idx_q, gcnt_q;
  logic [TW-1:0]    therm_q;
  logic             par_q;
  logic [31:0]      lfsr_q;
  logic [W-1:0]     flit_q, prev_q;
  logic             last_q;
  logic [CNT_W-1:0] toggle_q, fcnt_q;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LfsrMask : 32'h0);
  endfunction

  // Flit value derived from the per-pattern generator state of the flit to be presented.
  function automatic logic [W-1:0] gen_flit(input logic [1:0] m, input logic [TW-1:0] t,
                                            input logic par, input logic [31:0] s);
    logic [W-1:0] f;
    f = '0;
    unique case (m)
      2'd0: f = '0;
      2'd1: for (int i = 0; i < W; i++) f[i] = (i < int'(t));
      2'd2: f = par ? '0 : '1;
      default: for (int i = 0; i < W; i++) f[i] = s[5'(i % 32)];
    endcase
    return f;
  endfunction

  logic             xfer, pkt_end;
  logic [TW-1:0]    therm_nxt, ham;
  logic [31:0]      lfsr_nxt, seed_fix;
  logic [W-1:0]     flit_nxt, diff;
  logic [LEN_W-1:0] idx_nxt;
  logic [CNT_W:0]   tog_sum;
  logic [CNT_W-1:0] tog_nxt;

  always_comb begin
    xfer      = (state_q == StSend) && out_ready_i;
    pkt_end   = (idx_q == plen_q - LEN_W'(1));
    idx_nxt   = pkt_end ? '0 : idx_q + LEN_W'(1);
    therm_nxt = (therm_q == TW'(W)) ? '0 : therm_q + TW'(1);
    lfsr_nxt  = lfsr_step(lfsr_q);
    flit_nxt  = gen_flit(mode_q, therm_nxt, ~par_q, lfsr_nxt);
    seed_fix  = (seed_i == 32'h0) ? 32'h1 : seed_i;
    diff      = flit_q ^ prev_q;
    ham       = '0;
    for (int i = 0; i < W; i++) ham = ham + TW'(diff[i]);
    tog_sum   = {1'b0, toggle_q} + (CNT_W + 1)'(ham);
    tog_nxt   = tog_sum[CNT_W] ? '1 : tog_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      mode_q   <= '0;
      plen_q   <= '0;
      gap_q    <= '0;
      pkt_q    <= '0;
      idx_q    <= '0;
      gcnt_q   <= '0;
      therm_q  <= '0;
      par_q    <= 1'b0;
      lfsr_q   <= 32'h1;
      flit_q   <= '0;
      prev_q   <= '0;
      last_q   <= 1'b0;
      toggle_q <= '0;
      fcnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            mode_q   <= mode_i;
            plen_q   <= payload_len_i;
            gap_q    <= gap_len_i;
            pkt_q    <= num_pkts_i - LEN_W'(1);
            idx_q    <= '0;
            therm_q  <= '0;
            par_q    <= 1'b0;
            lfsr_q   <= seed_fix;
            flit_q   <= gen_flit(mode_i, '0, 1'b0, seed_fix);
            prev_q   <= '0;
            last_q   <= (payload_len_i == LEN_W'(1));
            toggle_q <= '0;
            fcnt_q   <= '0;
            state_q  <= (payload_len_i == '0 || num_pkts_i == '0) ? StDone : StSend;
          end
        end
        StSend: begin
          if (xfer) begin
            fcnt_q   <= fcnt_q + CNT_W'(1);
            toggle_q <= tog_nxt;
            prev_q   <= flit_q;
            therm_q  <= therm_nxt;
            par_q    <= ~par_q;
            lfsr_q   <= lfsr_nxt;
            flit_q   <= flit_nxt;
            idx_q    <= idx_nxt;
            last_q   <= (idx_nxt == plen_q - LEN_W'(1));
            if (pkt_end) begin
              if (pkt_q != '0) begin
                pkt_q <= pkt_q - LEN_W'(1);
                if (gap_q != '0) begin
                  state_q <= StGap;
                  gcnt_q  <= gap_q - LEN_W'(1);
                end
              end else begin
                state_q <= StDone;
              end
            end
          end
        end
        StGap: begin
          if (gcnt_q == '0) state_q <= StSend;
          else              gcnt_q  <= gcnt_q - LEN_W'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid_o    = (state_q == StSend);
  assign busy_o         = (state_q == StSend) || (state_q == StGap);
  assign done_o         = (state_q == StDone);
  assign out_last_o     = last_q && (state_q == StSend);
  assign op_a_o         = flit_q[N-1:0];
  assign op_b_o         = flit_q[W-1:N];
  assign toggle_count_o = toggle_q;
  assign flit_count_o   = fcnt_q;

endmodule

// File: doc/flit_stim_gen.md
Name: flit_stim_gen

Overview:
- Synthesizable, parametrised packet/flit stimulus generator for energy characterization of datapath blocks (adders and similar) under controlled switching activity and link utilization.
- Emits packets of 2N-bit flits in a selectable pattern family. Each flit is split into two N-bit operands.
- Inserts configurable idle gaps between packets, honours valid/ready backpressure, and accumulates an operand-bus toggle count as an activity figure.
- Sits between the characterization controller and the unit under test.

Parameters:
- N, 22, operand width; flit width W = 2N.
- LEN_W, 16, width of payload_len, gap_len and num_pkts.
- CNT_W, 32, width of toggle_count and flit_count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE or DONE
- mode  in  2  pattern: 0 ZERO, 1 THERMO, 2 ALT, 3 LFSR
- payload_len  in  LEN_W  flits per packet
- gap_len  in  LEN_W  idle cycles between packets
- num_pkts  in  LEN_W  packets per run
- seed  in  32  LFSR seed
- out_valid  out  1  flit available
- out_ready  in  1  consumer accepts flit
- op_a  out  N  flit[N-1:0]
- op_b  out  N  flit[2N-1:N]
- out_last  out  1  current flit is last of its packet
- busy  out  1  state is SEND or GAP
- done  out  1  run complete; sticky until next start or rst
- toggle_count  out  CNT_W  sum of Hamming distances between consecutive accepted flits
- flit_count  out  CNT_W  accepted flits this run

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: out_valid, out_last, busy, done, op_a, op_b, toggle_count, flit_count.
  - Reset mid-run aborts immediately; no further flits are issued.
- State machine: IDLE, SEND, GAP, DONE.
- Start:
  - start=1 in IDLE or DONE latches mode, payload_len, gap_len, num_pkts and seed.
  - It clears done, the counters, the flit index k and the previous-flit register (set to 0).
  - Next state is SEND. If payload_len=0 or num_pkts=0, next state is DONE and no flit is issued.
  - start is ignored in SEND and GAP.
- SEND:
  - out_valid=1. op_a, op_b and out_last are registered and stable while out_valid=1 and out_ready=0.
  - A transfer occurs on any cycle with out_valid=1 and out_ready=1.
  - On transfer: k increments, flit_count increments, and toggle_count += popcount(flit ^ prev); prev is then set to flit. toggle_count saturates at 2^CNT_W-1.
  - After the last flit of a packet: if packets remain and gap_len>0, go to GAP; if packets remain and gap_len=0, stay in SEND (back-to-back packets); otherwise go to DONE.
- GAP:
  - out_valid=0 for exactly gap_len cycles, then SEND.
  - op_a and op_b hold the next flit value.
- DONE:
  - done=1, out_valid=0; hold until start or rst.
- Latency: the first flit is valid on the cycle after start is sampled. With out_ready held at 1, one run takes num_pkts*payload_len + (num_pkts-1)*gap_len cycles in SEND/GAP.
- Flit value for global index k (counted across packets from 0 at start):
  - ZERO: all zeros.
  - THERMO: the low (k mod (W+1)) bits set, rest 0.
  - ALT: all ones for even k, all zeros for odd k.
  - LFSR: state s is loaded with seed (seed=0 is replaced by 1). Galois LFSR with mask 0x80200003: on each transfer, s = (s>>1) ^ (s[0] ? 0x80200003 : 0). Flit = {s,s,...} replicated and truncated to W bits; bits [31:0] are s.
- out_last = 1 when the in-packet flit index equals payload_len-1.

Test Plan:
- THERMO, N=22, payload_len=4, gap_len=2, num_pkts=2, ready=1, start at cycle 0:
  - out_valid in cycles 1-4 and 7-10; done=1 from cycle 11.
  - op_a = 0x0,0x1,0x3,0x7,0xF,0x1F,0x3F,0x7F; op_b=0 throughout.
  - out_last at cycles 4 and 10; toggle_count=7, flit_count=8.
- ALT, payload_len=3, num_pkts=1:
  - op_a/op_b = 0x3FFFFF/0x3FFFFF, then 0/0, then 0x3FFFFF/0x3FFFFF.
  - toggle_count=132.
- Backpressure: THERMO, out_ready=0 for 3 cycles while op_a=0x3 is presented:
  - op_a holds 0x3 and out_valid holds 1; flit_count does not advance.
  - Sequence resumes with 0x7 after ready returns.
- LFSR, seed=0:
  - First flit bits [31:0] = 0x00000001; second = 0x80200003 (after one step from 1).
  - Repeating with seed=1 gives an identical stream.
- Edge cases:
  - payload_len=0 -> done=1 on the next cycle with no out_valid pulse.
  - gap_len=0, num_pkts=2, payload_len=2 -> four consecutive valid cycles, out_last on the 2nd and 4th.
- rst asserted in the middle of packet 2 -> next cycle all outputs 0, state IDLE; a new start restarts with k=0.
